// File: rtl/rb_arbiter.sv
// -----------------------------------------------------------------------------
// rb_arbiter -- irrigation tank/zone controller with round-robin zone grant.
//
// A single Moore FSM serves two watering zones (sprinkler, drip) from a tank
// that is refilled through an inlet valve. A grant is held for at most MAX_RUN
// cycles and is always followed by COOLDOWN idle cycles. Implausible level
// sensor codes force an error state that is left only after ERR_HOLD
// consecutive plausible samples.
//
// Ports
//   clock              sole clock, rising edge
//   reset_n            asynchronous active-low reset
//   H, M, L            tank level sensors (1 = water at or above that level)
//   req_spr, req_drip  zone watering requests (level signals)
//   gnt_spr, gnt_drip  grant to the zone being served
//   pump               pump enable, high exactly while a zone is granted
//   valve_spr          sprinkler valve
//   valve_in           tank inlet valve
//   err                level sensor fault indication
//   busy               high whenever the FSM is not IDLE
//   state              current state encoding (debug/display)
// -----------------------------------------------------------------------------
module rb_arbiter #(
  parameter int unsigned MAX_RUN  = 16,
  parameter int unsigned COOLDOWN = 4,
  parameter int unsigned ERR_HOLD = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       H,
  input  logic       M,
  input  logic       L,
  input  logic       req_spr,
  input  logic       req_drip,
  output logic       gnt_spr,
  output logic       gnt_drip,
  output logic       pump,
  output logic       valve_spr,
  output logic       valve_in,
  output logic       err,
  output logic       busy,
  output logic [2:0] state
);

  localparam int unsigned RUN_W  = $clog2(MAX_RUN + 1);
  localparam int unsigned COOL_W = $clog2(COOLDOWN + 1);
  localparam int unsigned HOLD_W = $clog2(ERR_HOLD + 1);

  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MAX_RUN);
  localparam logic [COOL_W-1:0] COOL_MAX  = COOL_W'(COOLDOWN);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ERR_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_SPR  = 3'd2,
    S_DRIP = 3'd3,
    S_COOL = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [RUN_W-1:0]    run_q, run_d;     // cycles spent in the current grant
  logic [COOL_W-1:0]   cool_q, cool_d;   // cycles spent in COOL
  logic [HOLD_W-1:0]   ok_q, ok_d;       // consecutive plausible codes in ERR
  logic                last_spr_q, last_spr_d;  // 1: sprinkler served last

  logic level_ok;
  logic spr_elig;
  logic drip_elig;
  logic grant_req;

  // The tank fills bottom-up, so only "thermometer" codes are physically valid.
  assign level_ok  = ({H, M, L} == 3'b000) || ({H, M, L} == 3'b001) ||
                     ({H, M, L} == 3'b011) || ({H, M, L} == 3'b111);
  assign spr_elig  = req_spr & M;
  assign drip_elig = req_drip & L;
  assign grant_req = (state_q == S_SPR) ? req_spr : req_drip;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    state_d    = state_q;
    run_d      = run_q;
    cool_d     = cool_q;
    ok_d       = ok_q;
    last_spr_d = last_spr_q;

    case (state_q)
      S_IDLE: begin
        if (!L) begin
          state_d = S_FILL;
        end else if (spr_elig && drip_elig) begin
          state_d = last_spr_q ? S_DRIP : S_SPR;
        end else if (spr_elig) begin
          state_d = S_SPR;
        end else if (drip_elig) begin
          state_d = S_DRIP;
        end else if (req_spr || !H) begin
          // Sprinkler wants water but the tank is below M, or tank not full.
          state_d = S_FILL;
        end
        // The first granted cycle already counts as cycle 1.
        if (state_d == S_SPR || state_d == S_DRIP) begin
          run_d = RUN_W'(1);
        end
      end

      S_FILL: begin
        if (H) begin
          state_d = S_IDLE;
        end
      end

      S_SPR, S_DRIP: begin
        if (!grant_req || !L || run_q == RUN_MAX) begin
          state_d    = S_COOL;
          cool_d     = COOL_W'(1);
          last_spr_d = (state_q == S_SPR);
        end else begin
          run_d = run_q + RUN_W'(1);
        end
      end

      S_COOL: begin
        if (cool_q == COOL_MAX) begin
          state_d = S_IDLE;
        end else begin
          cool_d = cool_q + COOL_W'(1);
        end
      end

      S_ERR: begin
        if (!level_ok) begin
          ok_d = '0;
        end else if (ok_q == HOLD_LAST) begin
          state_d = S_FILL;
          ok_d    = '0;
        end else begin
          ok_d = ok_q + HOLD_W'(1);
        end
      end

      default: state_d = S_IDLE;  // unused encodings 6-7
    endcase

    // A sensor fault outranks every other transition.
    if (state_q != S_ERR && !level_ok) begin
      state_d = S_ERR;
      ok_d    = '0;
      if (state_q == S_SPR || state_q == S_DRIP) begin
        last_spr_d = (state_q == S_SPR);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      run_q      <= '0;
      cool_q     <= '0;
      ok_q       <= '0;
      last_spr_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      run_q      <= run_d;
      cool_q     <= cool_d;
      ok_q       <= ok_d;
      last_spr_q <= last_spr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decode (registered state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_spr   = 1'b0;
    gnt_drip  = 1'b0;
    pump      = 1'b0;
    valve_spr = 1'b0;
    valve_in  = 1'b0;
    err       = 1'b0;
    case (state_q)
      S_FILL: valve_in = 1'b1;
      S_SPR: begin
        gnt_spr   = 1'b1;
        pump      = 1'b1;
        valve_spr = 1'b1;
      end
      S_DRIP: begin
        gnt_drip = 1'b1;
        pump     = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  assign busy  = (state_q != S_IDLE);
  assign state = state_q;

endmodule

// File: tb/tb_rb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rb_arbiter -- self-checking bench for rb_arbiter.
// Directed vector table, hand-written multi-cycle sequences (run length,
// alternation, asynchronous reset) and a randomized run against a countdown
// based behavioural model of the controller.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rb_arbiter;

  localparam int MAX_RUN  = 16;
  localparam int COOLDOWN = 4;
  localparam int ERR_HOLD = 3;

  localparam int IDLE = 0, FILL = 1, SPR = 2, DRIP = 3, COOL = 4, ERR = 5;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       H, M, L;
  logic       req_spr, req_drip;
  logic       gnt_spr, gnt_drip, pump, valve_spr, valve_in, err, busy;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  rb_arbiter #(
    .MAX_RUN (MAX_RUN),
    .COOLDOWN(COOLDOWN),
    .ERR_HOLD(ERR_HOLD)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .H        (H),
    .M        (M),
    .L        (L),
    .req_spr  (req_spr),
    .req_drip (req_drip),
    .gnt_spr  (gnt_spr),
    .gnt_drip (gnt_drip),
    .pump     (pump),
    .valve_spr(valve_spr),
    .valve_in (valve_in),
    .err      (err),
    .busy     (busy),
    .state    (state)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // {state, gnt_spr, gnt_drip, pump, valve_spr, valve_in, err, busy}
  function automatic logic [9:0] dut_vec();
    return {state, gnt_spr, gnt_drip, pump, valve_spr, valve_in, err, busy};
  endfunction

  // Output table for each state, straight from the actuator descriptions.
  function automatic logic [9:0] outs_for(input int st);
    case (st)
      FILL:    return {3'd1, 7'b0000101};
      SPR:     return {3'd2, 7'b1011001};
      DRIP:    return {3'd3, 7'b0110001};
      COOL:    return {3'd4, 7'b0000001};
      ERR:     return {3'd5, 7'b0000011};
      default: return 10'd0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model: remaining-cycle budgets instead of up-counters.
  // ---------------------------------------------------------------------------
  int md, run_left, cool_left, ok_cnt;
  bit last_was_spr;

  task automatic model_reset();
    md = IDLE; run_left = 0; cool_left = 0; ok_cnt = 0; last_was_spr = 0;
  endtask

  task automatic model_step();
    logic [2:0] code;
    bit valid, want;
    int nxt;
    code  = {H, M, L};
    valid = (code == 3'b000) || (code == 3'b001) || (code == 3'b011) ||
            (code == 3'b111);
    nxt   = md;
    if (md != ERR && !valid) begin
      nxt = ERR;
      ok_cnt = 0;
    end else begin
      case (md)
        IDLE: begin
          if (!L) nxt = FILL;
          else if (req_spr && M && req_drip) nxt = last_was_spr ? DRIP : SPR;
          else if (req_spr && M) nxt = SPR;
          else if (req_drip) nxt = DRIP;
          else if (req_spr || !H) nxt = FILL;
          if (nxt == SPR || nxt == DRIP) run_left = MAX_RUN;
        end
        FILL: if (H) nxt = IDLE;
        SPR, DRIP: begin
          run_left--;
          want = (md == SPR) ? req_spr : req_drip;
          if (!want || !L || run_left == 0) begin
            nxt = COOL;
            cool_left = COOLDOWN;
          end
        end
        COOL: begin
          cool_left--;
          if (cool_left == 0) nxt = IDLE;
        end
        ERR: begin
          if (valid) begin
            ok_cnt++;
            if (ok_cnt == ERR_HOLD) begin
              nxt = FILL;
              ok_cnt = 0;
            end
          end else begin
            ok_cnt = 0;
          end
        end
        default: nxt = IDLE;
      endcase
    end
    if ((md == SPR || md == DRIP) && nxt != md) last_was_spr = (md == SPR);
    md = nxt;
  endtask

  // One clock: model consumes the inputs present at the edge, then sample.
  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic set_in(input logic [2:0] lvl, input logic rs, input logic rd);
    {H, M, L} = lvl;
    req_spr   = rs;
    req_drip  = rd;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [2:0] lvl;
    logic       rs;
    logic       rd;
    int         exp_state;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [2:0] codes[4];
    int order, granted, both_hi, n;
    logic prev_s, prev_d;
    logic [2:0] lvl;
    logic rs, rd;

    codes = '{3'b000, 3'b001, 3'b011, 3'b111};

    // Sequence from reset (last served = DRIP).
    vecs.push_back('{3'b111, 1'b1, 1'b1, SPR});   // tie -> SPR first
    vecs.push_back('{3'b111, 1'b0, 1'b1, COOL});  // request dropped
    vecs.push_back('{3'b111, 1'b0, 1'b1, COOL});
    vecs.push_back('{3'b111, 1'b0, 1'b1, COOL});
    vecs.push_back('{3'b111, 1'b1, 1'b1, COOL});  // 4th cool cycle
    vecs.push_back('{3'b111, 1'b1, 1'b1, IDLE});
    vecs.push_back('{3'b111, 1'b1, 1'b1, DRIP});  // tie -> DRIP now
    vecs.push_back('{3'b101, 1'b1, 1'b1, ERR});   // invalid code
    vecs.push_back('{3'b111, 1'b0, 1'b0, ERR});   // valid 1
    vecs.push_back('{3'b111, 1'b0, 1'b0, ERR});   // valid 2
    vecs.push_back('{3'b010, 1'b0, 1'b0, ERR});   // invalid -> restart
    vecs.push_back('{3'b111, 1'b0, 1'b0, ERR});   // valid 1
    vecs.push_back('{3'b111, 1'b0, 1'b0, ERR});   // valid 2
    vecs.push_back('{3'b111, 1'b0, 1'b0, FILL});  // valid 3 -> FILL
    vecs.push_back('{3'b111, 1'b0, 1'b0, IDLE});  // H=1 ends fill
    vecs.push_back('{3'b001, 1'b1, 1'b0, FILL});  // spr wants, M=0
    vecs.push_back('{3'b011, 1'b1, 1'b0, FILL});
    vecs.push_back('{3'b111, 1'b1, 1'b0, IDLE});
    vecs.push_back('{3'b111, 1'b1, 1'b0, SPR});
    vecs.push_back('{3'b000, 1'b1, 1'b0, COOL});  // L dropped
    vecs.push_back('{3'b000, 1'b1, 1'b0, COOL});
    vecs.push_back('{3'b000, 1'b1, 1'b0, COOL});
    vecs.push_back('{3'b000, 1'b1, 1'b0, COOL});
    vecs.push_back('{3'b000, 1'b1, 1'b0, IDLE});
    vecs.push_back('{3'b000, 1'b1, 1'b0, FILL});
    vecs.push_back('{3'b111, 1'b0, 1'b1, IDLE});
    vecs.push_back('{3'b111, 1'b0, 1'b1, DRIP});
    vecs.push_back('{3'b011, 1'b0, 1'b1, DRIP});  // L still 1
    vecs.push_back('{3'b111, 1'b0, 1'b0, COOL});

    // Reset state, checked before any clock edge.
    set_in(3'b111, 1'b0, 1'b0);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("reset_outputs", 32'(dut_vec()), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      set_in(vecs[i].lvl, vecs[i].rs, vecs[i].rd);
      tick();
      check($sformatf("vec%0d", i), 32'(dut_vec()), 32'(outs_for(vecs[i].exp_state)));
    end

    // Steady sprinkler demand: 16 granted cycles, 4 COOL, IDLE, grant again.
    set_in(3'b111, 1'b1, 1'b0);
    do_reset();
    tick();
    n = 0;
    while (gnt_spr && pump && valve_spr && n < 100) begin
      n++;
      tick();
    end
    check("spr_run_length", 32'(n), 32'(MAX_RUN));
    n = 0;
    while (state == 3'd4 && !pump && !valve_in && !gnt_spr && n < 100) begin
      n++;
      tick();
    end
    check("cool_length", 32'(n), 32'(COOLDOWN));
    check("idle_after_cool", 32'(dut_vec()), 32'(outs_for(IDLE)));
    tick();
    check("spr_regrant", 32'(dut_vec()), 32'(outs_for(SPR)));

    // Both zones requesting: grants alternate SPR, DRIP, SPR.
    set_in(3'b111, 1'b1, 1'b1);
    do_reset();
    order = 0; granted = 0; both_hi = 0; n = 0;
    prev_s = 1'b0; prev_d = 1'b0;
    while (granted < 3 && n < 300) begin
      tick();
      n++;
      if (gnt_spr && gnt_drip) both_hi++;
      if (gnt_spr && !prev_s) begin order = order * 4 + 1; granted++; end
      if (gnt_drip && !prev_d) begin order = order * 4 + 2; granted++; end
      prev_s = gnt_spr;
      prev_d = gnt_drip;
    end
    check("alternation_order", 32'(order), 32'(1 * 16 + 2 * 4 + 1));
    check("never_both_grants", 32'(both_hi), 32'd0);

    // Asynchronous reset mid-grant.
    set_in(3'b111, 1'b1, 1'b0);
    do_reset();
    tick();
    tick();
    check("spr_before_reset", 32'(dut_vec()), 32'(outs_for(SPR)));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_in_spr", 32'(dut_vec()), 32'd0);
    #2;
    reset_n = 1'b1;
    model_reset();
    #1;
    check("idle_after_release", 32'(dut_vec()), 32'(outs_for(IDLE)));
    tick();
    check("regrant_after_release", 32'(dut_vec()), 32'(outs_for(SPR)));

    // Asynchronous reset mid-fill.
    set_in(3'b001, 1'b0, 1'b0);
    do_reset();
    tick();
    check("fill_before_reset", 32'(dut_vec()), 32'(outs_for(FILL)));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_in_fill", 32'(dut_vec()), 32'd0);
    #2;
    reset_n = 1'b1;
    model_reset();

    // Randomized run against the behavioural model.
    set_in(3'b111, 1'b0, 1'b0);
    do_reset();
    lvl = 3'b111; rs = 1'b0; rd = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 15) == 0) lvl = 3'($urandom_range(0, 7));
        else if ($urandom_range(0, 1) == 0) lvl = 3'b111;
        else lvl = codes[$urandom_range(0, 3)];
      end
      if ($urandom_range(0, 9) == 0) rs = ~rs;
      if ($urandom_range(0, 9) == 0) rd = ~rd;
      set_in(lvl, rs, rd);
      tick();
      check($sformatf("rand%0d", cyc), 32'(dut_vec()), 32'(outs_for(md)));
      check($sformatf("rand_safety%0d", cyc),
            32'({gnt_spr & gnt_drip, pump ^ (gnt_spr | gnt_drip), valve_in & pump}),
            32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
